operand_fetch_sequencer: RTL and testbench

Sequences the input data latch during operand fetch. After the opcode cycle, it fetches the 0, 1 or 2 little-endian operand bytes that follow the opcode, and drives the bus address, RWB and latch strobes while doing so. It honours RDY stalls and presents the assembled 16-bit operand plus the updated program counter to the decode/execute stage. It sits between instruction decode and the input data latch, and replaces ad-hoc toggle-based byte steering.

---
 rtl/cpu65_pkg.sv | 22 ++
 rtl/operand_fetch_sequencer.sv | 103 ++++++++++
 tb/tb_operand_fetch_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu65_pkg.sv
`default_nettype none
// ==== cpu65_pkg : shared types and constants for the 65xx-style core (rev 1.0) ====
package cpu65_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FETCH_LO = 2'd1,
      ST_FETCH_HI = 2'd2,
      ST_DONE     = 2'd3
   } fetch_state_t;

   localparam logic [1:0] OPLEN_NONE = 2'd0;
   localparam logic [1:0] OPLEN_BYTE = 2'd1;
   localparam logic [1:0] OPLEN_WORD = 2'd2;

   // Length code 3 has no meaning on the bus; fold it onto a word fetch.
   function automatic logic [1:0] norm_oplen(input logic [1:0] len);
      return (len == 2'd3) ? OPLEN_WORD : len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_sequencer.sv
`default_nettype none
// ==== operand_fetch_sequencer : fetches 0-2 little-endian operand bytes after the opcode (rev 1.0) ====
module operand_fetch_sequencer
   import cpu65_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic                fclk,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          op_len,
   input  logic [ADDR_W-1:0]   pc_in,
   input  logic                rdy,
   input  logic [DATA_W-1:0]   db_in,
   output logic [ADDR_W-1:0]   addr,
   output logic                rwb,
   output logic                latch_clear,
   output logic                latch_load,
   output logic [2*DATA_W-1:0] operand,
   output logic [ADDR_W-1:0]   pc_next,
   output logic                operand_valid,
   output logic                busy
);

   localparam logic [ADDR_W-1:0] C_ONE = ADDR_W'(1);

   fetch_state_t        r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [2*DATA_W-1:0] r_operand;
   logic [ADDR_W-1:0]   r_pc_next;
   logic [1:0]          r_len;

   logic [ADDR_W-1:0]   w_addr_inc;
   logic                w_fetching;

   // Wraps modulo 2^ADDR_W; the carry is intentionally dropped.
   assign w_addr_inc = r_addr + C_ONE;
   assign w_fetching = (r_state == ST_FETCH_LO) || (r_state == ST_FETCH_HI);

   always_ff @(posedge fclk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_operand <= '0;
         r_pc_next <= '0;
         r_len     <= OPLEN_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_operand <= '0;
                  r_addr    <= pc_in;
                  r_len     <= norm_oplen(op_len);
                  if (op_len == OPLEN_NONE) begin
                     r_pc_next <= pc_in;
                     r_state   <= ST_DONE;
                  end else begin
                     r_state   <= ST_FETCH_LO;
                  end
               end
            end
            ST_FETCH_LO: begin
               if (rdy) begin
                  r_operand[DATA_W-1:0] <= db_in;
                  r_addr                <= w_addr_inc;
                  if (r_len == OPLEN_WORD) begin
                     r_state <= ST_FETCH_HI;
                  end else begin
                     r_pc_next <= w_addr_inc;
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_FETCH_HI: begin
               if (rdy) begin
                  r_operand[2*DATA_W-1:DATA_W] <= db_in;
                  r_addr                       <= w_addr_inc;
                  r_pc_next                    <= w_addr_inc;
                  r_state                      <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign addr          = r_addr;
   assign rwb           = 1'b1;
   assign latch_clear   = start && (r_state == ST_IDLE);
   assign latch_load    = rdy && w_fetching;
   assign operand       = r_operand;
   assign pc_next       = r_pc_next;
   assign operand_valid = (r_state == ST_DONE);
   assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_sequencer.sv
`default_nettype none
// ==== tb_operand_fetch_sequencer : directed scoreboard bench for operand_fetch_sequencer (rev 1.0) ====
module tb_operand_fetch_sequencer;

   logic        fclk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op_len;
   logic [15:0] pc_in;
   logic        rdy;
   logic [7:0]  db_in;
   logic [15:0] addr;
   logic        rwb;
   logic        latch_clear;
   logic        latch_load;
   logic [15:0] operand;
   logic [15:0] pc_next;
   logic        operand_valid;
   logic        busy;

   operand_fetch_sequencer #(.ADDR_W(16), .DATA_W(8)) dut (
      .fclk(fclk), .reset(reset), .start(start), .op_len(op_len), .pc_in(pc_in),
      .rdy(rdy), .db_in(db_in), .addr(addr), .rwb(rwb), .latch_clear(latch_clear),
      .latch_load(latch_load), .operand(operand), .pc_next(pc_next),
      .operand_valid(operand_valid), .busy(busy)
   );

   always #5 fclk = ~fclk;

   typedef struct {
      logic [15:0] op;
      logic [15:0] pc;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge fclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge fclk);
      #1;
   endtask

   task automatic mid();
      @(negedge fclk);
   endtask

   task automatic push(input logic [15:0] op, input logic [15:0] pc, input int lat);
      exp_t e;
      e.op  = op;
      e.pc  = pc;
      e.cyc = cyc + lat;
      q.push_back(e);
   endtask

   // Monitor: every operand_valid must match the oldest outstanding expectation.
   always @(negedge fclk) begin
      if (operand_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got operand_valid=1 expected 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("operand", 32'(operand), 32'(e.op));
            chk("pc_next", 32'(pc_next), 32'(e.pc));
            chk("latency_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; start = 1'b0; op_len = 2'd0; pc_in = 16'h0; rdy = 1'b1; db_in = 8'h0;
      tick(); tick();
      mid();
      chk("rst_addr", 32'(addr), 32'h0);
      chk("rst_operand", 32'(operand), 32'h0);
      chk("rst_pc_next", 32'(pc_next), 32'h0);
      chk("rst_valid", 32'(operand_valid), 32'h0);
      chk("rst_clear", 32'(latch_clear), 32'h0);
      chk("rst_load", 32'(latch_load), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rwb", 32'(rwb), 32'h1);
      tick(); reset = 1'b0;
      mid();
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_load", 32'(latch_load), 32'h0);

      // Word operand 0xABCD at 0x1234
      tick(); start = 1'b1; op_len = 2'd2; pc_in = 16'h1234; push(16'hABCD, 16'h1236, 3);
      mid(); chk("w_clear", 32'(latch_clear), 32'h1);
      tick(); start = 1'b0; db_in = 8'hCD;
      mid(); chk("w_addr_lo", 32'(addr), 32'h1234); chk("w_load_lo", 32'(latch_load), 32'h1);
      chk("w_busy", 32'(busy), 32'h1);
      tick(); db_in = 8'hAB;
      mid(); chk("w_addr_hi", 32'(addr), 32'h1235); chk("w_load_hi", 32'(latch_load), 32'h1);
      tick();
      mid(); chk("w_done_load", 32'(latch_load), 32'h0);
      tick();
      mid(); chk("w_idle_busy", 32'(busy), 32'h0);

      // Byte operand at 0xFFFF: address wraps to 0x0000
      tick(); start = 1'b1; op_len = 2'd1; pc_in = 16'hFFFF; push(16'h0042, 16'h0000, 2);
      mid(); chk("b_clear", 32'(latch_clear), 32'h1);
      tick(); start = 1'b0; db_in = 8'h42;
      mid(); chk("b_addr", 32'(addr), 32'hFFFF);
      tick();
      mid(); chk("b_addr_wrap", 32'(addr), 32'h0000);
      tick();

      // No operand at 0x0200
      tick(); start = 1'b1; op_len = 2'd0; pc_in = 16'h0200; push(16'h0000, 16'h0200, 1);
      mid(); chk("n_clear", 32'(latch_clear), 32'h1);
      tick(); start = 1'b0;
      mid(); chk("n_load", 32'(latch_load), 32'h0); chk("n_busy", 32'(busy), 32'h1);
      tick();

      // Word operand at 0x3000 with a 2-cycle stall in FETCH_HI and ignored starts
      tick(); start = 1'b1; op_len = 2'd2; pc_in = 16'h3000; push(16'h5A77, 16'h3002, 5);
      mid();
      tick(); start = 1'b0; db_in = 8'h77;
      mid(); chk("s_addr_lo", 32'(addr), 32'h3000);
      tick(); rdy = 1'b0; db_in = 8'hEE; start = 1'b1; op_len = 2'd1; pc_in = 16'h9999;
      mid(); chk("s_addr_st1", 32'(addr), 32'h3001); chk("s_load_st1", 32'(latch_load), 32'h0);
      chk("s_lo_byte1", 32'(operand[7:0]), 32'h77); chk("s_clear_busy", 32'(latch_clear), 32'h0);
      tick();
      mid(); chk("s_addr_st2", 32'(addr), 32'h3001); chk("s_load_st2", 32'(latch_load), 32'h0);
      chk("s_lo_byte2", 32'(operand[7:0]), 32'h77);
      tick(); rdy = 1'b1; start = 1'b0; db_in = 8'h5A;
      mid(); chk("s_addr_hi", 32'(addr), 32'h3001); chk("s_load_hi", 32'(latch_load), 32'h1);
      // start held through DONE is ignored there and accepted on the next cycle
      tick(); start = 1'b1; op_len = 2'd0; pc_in = 16'h4000;
      mid(); chk("d_clear_in_done", 32'(latch_clear), 32'h0);
      tick(); push(16'h0000, 16'h4000, 1);
      mid(); chk("d_clear_after", 32'(latch_clear), 32'h1);
      tick(); start = 1'b0;
      mid();
      tick();

      // Reset in FETCH_HI aborts the fetch without a valid pulse
      tick(); start = 1'b1; op_len = 2'd2; pc_in = 16'h5000;
      mid();
      tick(); start = 1'b0; db_in = 8'h11;
      mid();
      tick(); rdy = 1'b0; reset = 1'b1;
      mid(); chk("r_busy_hi", 32'(busy), 32'h1); chk("r_addr_hi", 32'(addr), 32'h5001);
      tick(); reset = 1'b0; rdy = 1'b1;
      mid(); chk("r_busy", 32'(busy), 32'h0); chk("r_valid", 32'(operand_valid), 32'h0);
      chk("r_addr", 32'(addr), 32'h0); chk("r_operand", 32'(operand), 32'h0);
      tick();
      mid(); chk("r_valid2", 32'(operand_valid), 32'h0);
      tick(); start = 1'b1; op_len = 2'd3; pc_in = 16'h6000; push(16'h1234, 16'h6002, 3);
      mid();
      tick(); start = 1'b0; db_in = 8'h34;
      mid(); chk("p_addr_lo", 32'(addr), 32'h6000);
      tick(); db_in = 8'h12;
      mid(); chk("p_addr_hi", 32'(addr), 32'h6001);
      tick(); tick(); tick();
      mid();
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
